// File: rtl/formula_driver.sv
// formula_driver: operand source and in-order result checker for the formula pipeline.
// Optional feature: define FORMULA_DRV_STALL_EN to drop res_ready one cycle in four.
module formula_driver #(
   parameter int WIDTH   = 8,
   parameter int NUM_OPS = 16,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255,
   localparam int RW     = 2*WIDTH+3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [WIDTH-1:0]        seed,
   output logic signed [WIDTH-1:0] a,
   output logic signed [WIDTH-1:0] b,
   output logic signed [WIDTH-1:0] c,
   output logic signed [WIDTH-1:0] d,
   output logic                    op_valid,
   input  logic                    op_ready,
   input  logic signed [RW-1:0]    res,
   input  logic                    res_valid,
   output logic                    res_ready,
   output logic                    busy,
   output logic                    done,
   output logic                    timeout,
   output logic [7:0]              err_cnt,
   output logic [15:0]             recv_cnt
);

   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam int WDW = $clog2(TIMEOUT + 1);
   localparam logic [15:0]        NUM_OPS_C = 16'(NUM_OPS);
   localparam logic signed [RW-1:0] ONE     = RW'(1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                state, state_next;
   logic                  run, run_start, op_hs, res_hs, push, pop;
   logic                  fifo_empty, mismatch, wd_expire, last_res;
   logic [WIDTH-1:0]      k;
   logic [15:0]           sent;
   logic signed [RW-1:0]  fifo_mem [DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         fifo_count;
   logic [WDW-1:0]        wd_cnt;
   logic signed [RW-1:0]  ea, eb, ec, ed, diff, mult, sum, exp_val;

   // Operands are zero outside RUN so the port values match the reset state.
   assign run  = (state == S_RUN);
   assign busy = run;
   assign done = (state == S_DONE);
   assign a    = run ? k : '0;
   assign b    = run ? ~k : '0;
   assign c    = run ? k + WIDTH'(1) : '0;
   assign d    = run ? k - WIDTH'(1) : '0;

   assign op_valid   = run && (sent < NUM_OPS_C) && (fifo_count < CW'(DEPTH));
   assign op_hs      = op_valid && op_ready;
   assign res_hs     = res_valid && res_ready;
   assign fifo_empty = (fifo_count == '0);
   assign push       = op_hs;
   assign pop        = res_hs && !fifo_empty;
   assign mismatch   = res_hs && (fifo_empty || (res != fifo_mem[rd_ptr]));
   assign wd_expire  = run && !fifo_empty && !res_hs && (wd_cnt == WDW'(TIMEOUT - 1));
   assign last_res   = res_hs && (recv_cnt == NUM_OPS_C - 16'd1);

`ifdef FORMULA_DRV_STALL_EN
   logic [1:0] stall_cnt;

   always_ff @(posedge clk) begin
      if (rst) stall_cnt <= 2'd0;
      else     stall_cnt <= stall_cnt + 2'd1;
   end

   assign res_ready = run && (stall_cnt != 2'd3);
`else
   assign res_ready = run;
`endif

   // Every term is widened with sign before arithmetic; shift is arithmetic.
   always_comb begin
      ea      = RW'(a);
      eb      = RW'(b);
      ec      = RW'(c);
      ed      = RW'(d);
      diff    = ea - eb;
      mult    = (ec <<< 1) + ec + ONE;
      sum     = diff * mult + (ed <<< 2);
      exp_val = sum >>> 1;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      run_start  = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_next = S_RUN;
               run_start  = 1'b1;
            end
         end
         S_RUN: begin
            if (last_res || wd_expire) state_next = S_DONE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= exp_val;
   end

   // Counters and FIFO pointers; entering RUN flushes anything left from a prior run.
   always_ff @(posedge clk) begin
      if (rst || run_start) begin
         k          <= rst ? '0 : seed;
         sent       <= '0;
         recv_cnt   <= '0;
         err_cnt    <= '0;
         timeout    <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         wd_cnt     <= '0;
      end else if (run) begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
            k      <= k + WIDTH'(1);
            sent   <= sent + 16'd1;
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      fifo_count <= fifo_count + CW'(1);
         else if (pop && !push) fifo_count <= fifo_count - CW'(1);
         if (res_hs) begin
            recv_cnt <= recv_cnt + 16'd1;
            wd_cnt   <= '0;
         end else if (!fifo_empty) begin
            wd_cnt <= wd_cnt + WDW'(1);
         end
         if (mismatch && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
         if (wd_expire) timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_formula_driver.sv
// tb_formula_driver: randomized traffic against an integer-arithmetic reference of the driver.
// Honours FORMULA_DRV_STALL_EN when checking res_ready.
module tb_formula_driver;

   localparam int WIDTH   = 8;
   localparam int NUM_OPS = 12;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 40;
   localparam int RW      = 2*WIDTH+3;

   logic                    clk = 1'b0;
   logic                    rst, start, op_ready, res_valid;
   logic [WIDTH-1:0]        seed;
   logic signed [RW-1:0]    res;
   logic signed [WIDTH-1:0] a, b, c, d;
   logic                    op_valid, res_ready, busy, done, timeout;
   logic [7:0]              err_cnt;
   logic [15:0]             recv_cnt;

   int checks = 0;
   int errors = 0;

   logic [RW-1:0]    pipe_q[$];
   logic [RW-1:0]    exp_q[$];
   logic [WIDTH-1:0] model_k;
   int               model_recv, model_err, ops_sent;
   int               p_ready, p_resp, corrupt_k;
   bit               inject, in_run;

   formula_driver #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .start(start), .seed(seed),
      .a(a), .b(b), .c(c), .d(d),
      .op_valid(op_valid), .op_ready(op_ready),
      .res(res), .res_valid(res_valid), .res_ready(res_ready),
      .busy(busy), .done(done), .timeout(timeout),
      .err_cnt(err_cnt), .recv_cnt(recv_cnt)
   );

   always #5 clk = ~clk;

`ifdef FORMULA_DRV_STALL_EN
   logic [1:0] stall_model;
   always @(posedge clk) stall_model <= rst ? 2'd0 : stall_model + 2'd1;
   function automatic logic expResReady();
      return stall_model != 2'd3;
   endfunction
`else
   function automatic logic expResReady();
      return 1'b1;
   endfunction
`endif

   function automatic logic [RW-1:0] golden(input logic signed [WIDTH-1:0] fa, fb, fc, fd);
      int t;
      t = (int'(fa) - int'(fb)) * (3*int'(fc) + 1) + 4*int'(fd);
      return RW'(t >>> 1);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic bumpErr();
      if (model_err < 255) model_err++;
   endtask

   // One clock of pipeline behaviour; called and returns at a falling edge.
   task automatic applyStimulus();
      logic          op_hs, res_hs, injected;
      logic [RW-1:0] got, head;
      logic [7:0]    eb, ec, ed;
      injected  = 1'b0;
      op_ready  = ($urandom_range(99) < p_ready);
      res_valid = 1'b0;
      res       = '0;
      if (inject) begin
         res_valid = 1'b1;
         res       = RW'($urandom);
         inject    = 1'b0;
         injected  = 1'b1;
      end else if (pipe_q.size() != 0 && $urandom_range(99) < p_resp) begin
         res_valid = 1'b1;
         res       = pipe_q[0];
      end
      #1;
      if (in_run) checkOutput("res_ready", res_ready, expResReady());
      res_hs = res_valid && res_ready;
      op_hs  = op_valid && op_ready;
      if (res_hs) begin
         if (!injected) void'(pipe_q.pop_front());
         model_recv++;
         if (exp_q.size() == 0) bumpErr();
         else begin
            head = exp_q.pop_front();
            if (head != res) bumpErr();
         end
      end
      if (op_hs) begin
         eb = ~model_k;
         ec = model_k + 8'd1;
         ed = model_k - 8'd1;
         checkOutput("op_a", $unsigned(a), model_k);
         checkOutput("op_b", $unsigned(b), eb);
         checkOutput("op_c", $unsigned(c), ec);
         checkOutput("op_d", $unsigned(d), ed);
         got = golden(a, b, c, d);
         if (int'(model_k) == corrupt_k) got = got + RW'(1);
         pipe_q.push_back(got);
         exp_q.push_back(golden(model_k, eb, ec, ed));
         model_k = model_k + 8'd1;
         ops_sent++;
      end
      @(posedge clk);
      #1;
      if (in_run) begin
         checkOutput("err_cnt", err_cnt, model_err);
         checkOutput("recv_cnt", recv_cnt, model_recv);
      end
      @(negedge clk);
   endtask

   task automatic startRun(input logic [7:0] s);
      seed      = s;
      start     = 1'b1;
      op_ready  = 1'b0;
      res_valid = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      model_k = s; model_recv = 0; model_err = 0; ops_sent = 0;
      exp_q.delete(); pipe_q.delete();
      in_run = 1'b1;
      checkOutput("start_busy", busy, 1);
      checkOutput("start_op_valid", op_valid, 1);
      checkOutput("start_done", done, 0);
      checkOutput("start_timeout", timeout, 0);
      checkOutput("start_err", err_cnt, 0);
      checkOutput("start_recv", recv_cnt, 0);
   endtask

   task automatic runToDone(input string tag, input int budget);
      int n = 0;
      while (model_recv < NUM_OPS && n < budget) begin
         applyStimulus();
         n++;
         if (model_recv < NUM_OPS) checkOutput({tag, "_busy"}, busy, 1);
      end
      checkOutput({tag, "_done"}, done, 1);
      checkOutput({tag, "_busy_end"}, busy, 0);
      checkOutput({tag, "_recv_end"}, recv_cnt, NUM_OPS);
      checkOutput({tag, "_err_end"}, err_cnt, model_err);
      checkOutput({tag, "_timeout_end"}, timeout, 0);
      in_run = 1'b0;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_a"}, $unsigned(a), 0);
      checkOutput({tag, "_b"}, $unsigned(b), 0);
      checkOutput({tag, "_c"}, $unsigned(c), 0);
      checkOutput({tag, "_d"}, $unsigned(d), 0);
      checkOutput({tag, "_op_valid"}, op_valid, 0);
      checkOutput({tag, "_res_ready"}, res_ready, 0);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_done"}, done, 0);
      checkOutput({tag, "_timeout"}, timeout, 0);
      checkOutput({tag, "_err"}, err_cnt, 0);
      checkOutput({tag, "_recv"}, recv_cnt, 0);
   endtask

   initial begin : main
      logic [7:0] s, ck;
      int n;
      rst = 1'b1; start = 1'b0; seed = '0; op_ready = 1'b0; res_valid = 1'b0; res = '0;
      inject = 1'b0; in_run = 1'b0; corrupt_k = -1; p_ready = 100; p_resp = 100;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkResetValues("reset");
      rst = 1'b0;

      $display("[TB] golden run seed 0");
      startRun(8'd0);
      runToDone("golden", 400);
      checkOutput("golden_err_zero", err_cnt, 0);
      checkOutput("golden_ops", ops_sent, NUM_OPS);

      $display("[TB] corrupted result for k=1");
      corrupt_k = 1;
      startRun(8'd0);
      runToDone("corrupt", 400);
      checkOutput("corrupt_err_one", err_cnt, 1);
      corrupt_k = -1;

      $display("[TB] op_ready hold, FIFO fill and resume");
      startRun(8'h40);
      p_ready = 0; p_resp = 0;
      repeat (5) begin
         applyStimulus();
         checkOutput("hold_a", $unsigned(a), 8'h40);
         checkOutput("hold_b", $unsigned(b), 8'hBF);
         checkOutput("hold_c", $unsigned(c), 8'h41);
         checkOutput("hold_d", $unsigned(d), 8'h3F);
         checkOutput("hold_valid", op_valid, 1);
      end
      p_ready = 100;
      repeat (7) applyStimulus();
      checkOutput("fill_ops", ops_sent, DEPTH);
      checkOutput("fill_valid_low", op_valid, 0);
      p_ready = 0; p_resp = 100; n = 0;
      while (model_recv == 0 && n < 10) begin applyStimulus(); n++; end
      checkOutput("resume_valid", op_valid, 1);
      p_ready = 100;
      runToDone("stall", 400);
      checkOutput("stall_ops", ops_sent, NUM_OPS);

      $display("[TB] unexpected result");
      startRun(8'd5);
      inject = 1'b1;
      runToDone("unexpected", 400);

      $display("[TB] randomized runs");
      for (int r = 0; r < 4; r++) begin
         s  = 8'($urandom);
         ck = s + 8'($urandom_range(NUM_OPS-1));
         corrupt_k = (r % 2 == 1) ? int'(ck) : -1;
         p_ready = $urandom_range(30, 100);
         p_resp  = $urandom_range(50, 100);
         startRun(s);
         runToDone("random", 800);
      end
      corrupt_k = -1;

      $display("[TB] watchdog");
      p_ready = 100; p_resp = 0;
      startRun(8'd9);
      n = 0;
      while (ops_sent == 0 && n < 5) begin applyStimulus(); n++; end
      n = 0;
      while (!done && n < 3*TIMEOUT) begin applyStimulus(); n++; end
      in_run = 1'b0;
      checkOutput("wd_cycles", n, TIMEOUT);
      checkOutput("wd_timeout", timeout, 1);
      checkOutput("wd_done", done, 1);
      checkOutput("wd_busy", busy, 0);
      checkOutput("wd_recv", recv_cnt, 0);
      p_resp = 100;
      startRun(8'd9);
      runToDone("after_wd", 400);

      $display("[TB] reset mid-run");
      p_ready = 100; p_resp = 0;
      startRun(8'h80);
      n = 0;
      while (ops_sent < 2 && n < 10) begin applyStimulus(); n++; end
      in_run = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkResetValues("midrst");
      rst = 1'b0;
      p_resp = 100;
      startRun(8'h80);
      runToDone("post_rst", 400);
      checkOutput("post_rst_ops", ops_sent, NUM_OPS);
      checkOutput("post_rst_err", err_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : guard
      #500000;
      $display("[TB] FAIL global_timeout observed=running expected=finished");
      $fatal(1, "[TB] simulation time limit");
   end

endmodule

// File: doc/formula_driver.md
# formula_driver

Traffic source and result checker for the `formula` pipeline, which computes `((a-b)*(3c+1) + 4d) >>> 1`.
- Generates operand tuples a/b/c/d on a valid/ready master port.
- Keeps an in-order FIFO of expected results and consumes q on a valid/ready slave port.
- Compares each returned result against its expected value and counts mismatches.
- Sits at the opposite end of both handshakes of the pipeline; used in bring-up and in self-test.

## Interface
- WIDTH, 8: operand width; result width is RW = 2*WIDTH+3.
- NUM_OPS, 16: transactions per run, 1..65535.
- DEPTH, 4: expected-FIFO entries (power of 2, ≥2); bounds outstanding transactions.
- TIMEOUT, 255: max cycles to wait for a result while the FIFO is non-empty.
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE or DONE.
- seed  in  WIDTH  initial transaction index k.
- a, b, c, d  out  WIDTH each  signed operands.
- op_valid  out  1  operands valid.
- op_ready  in  1  pipeline accepts operands.
- res  in  RW  signed result from the pipeline.
- res_valid  in  1  result valid.
- res_ready  out  1  driver accepts result.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- timeout  out  1  run ended by watchdog; sticky until next start.
- err_cnt  out  8  mismatches plus unexpected results; saturates at 255.
- recv_cnt  out  16  results consumed this run.

## Operation
- States:
  - IDLE: start -> RUN.
  - RUN: recv_cnt==NUM_OPS -> DONE; watchdog expiry -> DONE with timeout=1.
  - DONE: start -> RUN.
- start in RUN is ignored.
- On entry to RUN: k<=seed, sent/recv/err counters cleared, timeout cleared, FIFO flushed.
- Operands are combinational from k, modulo 2^WIDTH, signed: a=k, b=~k, c=k+1, d=k-1.
- Expected value: exp = ((a-b)*(3c+1) + 4d) >>> 1.
  - Every term is sign-extended to RW before the operation.
  - The shift is arithmetic.
- op_valid = RUN && sent<NUM_OPS && fifo_count<DEPTH.
- On op handshake (op_valid && op_ready): push exp, k<=k+1 (wraps), sent<=sent+1.
- a/b/c/d hold stable while op_valid && !op_ready.
- res_ready = RUN (subject to Configuration).
- On res handshake (res_valid && res_ready):
  - recv_cnt<=recv_cnt+1.
  - FIFO non-empty: pop; if res != head, err_cnt++.
  - FIFO empty (unexpected result): err_cnt++, nothing popped.
- Simultaneous push and pop: fifo_count unchanged; a push into a full FIFO cannot occur because op_valid gates it.
- Watchdog:
  - Counts cycles in RUN with FIFO non-empty and no res handshake.
  - Clears on every res handshake.
  - Reaching TIMEOUT forces DONE.
- err_cnt saturates at 255.

## Timing
- Reset values: state IDLE; a/b/c/d=0; op_valid=0; res_ready=0; busy=0; done=0; timeout=0; err_cnt=0; recv_cnt=0; FIFO empty.
- start high in cycle N -> busy and op_valid high in N+1 (when NUM_OPS≥1).
- At most one op and one res handshake per cycle.
- Sustained one op per cycle while op_ready=1 and the FIFO is not full.
- Comparison result lands in err_cnt one cycle after the res handshake.
- done asserts the cycle after the final handshake; busy deasserts in the same cycle.
- rst mid-run: everything returns to reset values on the next edge; the in-flight FIFO is discarded.

## Configuration
- FORMULA_DRV_STALL_EN defined:
  - res_ready = RUN && (stall_cnt != 3).
  - stall_cnt is a free-running 2-bit counter cleared by rst.
  - res_ready therefore drops one cycle in four, exercising downstream backpressure.
- Not defined: res_ready = RUN; no stall counter is present.

## Test plan
- WIDTH=8, seed=0, NUM_OPS=3, golden pipeline -> operands (0,-1,1,-1), (1,-2,2,0), (2,-3,3,1); expected 0, 10, 27; done=1, err_cnt=0, recv_cnt=3.
- op_ready held 0 for 5 cycles -> a/b/c/d and op_valid stable; after release, each transaction is issued exactly once.
- Pipeline stalled with DEPTH=4 -> op_valid drops after 4 handshakes; resumes on the first pop.
- Pipeline returns 11 instead of 10 for k=1 -> err_cnt=1 at end, recv_cnt=3.
- Pipeline never returns a result -> timeout=1 and done=1 exactly TIMEOUT cycles after the first push.
- rst asserted mid-run after 2 pushes -> all outputs at reset values; a new start completes cleanly; with FORMULA_DRV_STALL_EN, res_ready is low every 4th cycle.
